// File: rtl/mat_mult_sched.sv
// Round-robin scheduler that time-shares one mat_mult datapath among N_REQ requesters.
// Each operation runs IDLE -> CLEAR -> RUN -> DONE, with a RUN-phase watchdog.
module mat_mult_sched #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned IDX_W   = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             mult_clr,
    output logic             enable_mult,
    input  logic             mult_done,
    output logic [N_REQ-1:0] ack,
    output logic             err,
    output logic             busy,
    output logic [15:0]      op_count,
    output logic [15:0]      last_latency
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StClear = 2'd1;
    localparam logic [1:0] StRun   = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    logic [1:0]       state_q;
    logic [IDX_W-1:0] rr_ptr_q;
    logic [N_REQ-1:0] grant_q;
    logic [IDX_W-1:0] grant_idx_q;
    logic [15:0]      run_cnt_q;
    logic             timeout_q;
    logic [15:0]      op_count_q;
    logic [15:0]      last_latency_q;

    logic             win_found;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W-1:0] cand_idx;
    logic             run_expired;

    // Search upward from rr_ptr with wrap; the first set request wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand_idx  = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand_idx = IDX_W'((32'(rr_ptr_q) + i) % N_REQ);
            if (!win_found && req[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    assign run_expired = ((32'(run_cnt_q) + 32'd1) == TIMEOUT);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= StIdle;
            rr_ptr_q       <= '0;
            grant_q        <= '0;
            grant_idx_q    <= '0;
            run_cnt_q      <= '0;
            timeout_q      <= 1'b0;
            op_count_q     <= '0;
            last_latency_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (win_found) begin
                        grant_q     <= {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
                        grant_idx_q <= win_idx;
                        rr_ptr_q    <= IDX_W'((32'(win_idx) + 32'd1) % N_REQ);
                        state_q     <= StClear;
                    end
                end
                StClear: begin
                    // mult_done here belongs to the previous result and is ignored.
                    run_cnt_q <= '0;
                    timeout_q <= 1'b0;
                    state_q   <= StRun;
                end
                StRun: begin
                    if (mult_done) begin
                        last_latency_q <= run_cnt_q + 16'd1;
                        op_count_q     <= op_count_q + 16'd1;
                        state_q        <= StDone;
                    end else if (run_expired) begin
                        timeout_q      <= 1'b1;
                        last_latency_q <= 16'(TIMEOUT);
                        op_count_q     <= op_count_q + 16'd1;
                        state_q        <= StDone;
                    end else begin
                        run_cnt_q <= run_cnt_q + 16'd1;
                    end
                end
                default: begin
                    grant_q     <= '0;
                    grant_idx_q <= '0;
                    state_q     <= StIdle;
                end
            endcase
        end
    end

    // Outputs decode registered state only; nothing passes through from req or mult_done.
    assign grant        = grant_q;
    assign grant_idx    = grant_idx_q;
    assign busy         = (state_q != StIdle);
    assign mult_clr     = (state_q == StClear);
    assign enable_mult  = (state_q == StRun);
    assign ack          = (state_q == StDone) ? grant_q : '0;
    assign err          = (state_q == StDone) && timeout_q;
    assign op_count     = op_count_q;
    assign last_latency = last_latency_q;

endmodule

// File: tb/tb_mat_mult_sched.sv
// Bench for mat_mult_sched: two instances (TIMEOUT 8 and 5) share stimulus and are
// checked every cycle against an operation-level model, plus directed literal checks.
module tb_mat_mult_sched;

    localparam int N = 4;

    typedef struct packed {
        int   owner;    // -1 when nobody holds the datapath
        int   age;      // cycles since grant; 0 = clear cycle, k = k-th run cycle
        int   run_len;  // nonzero once the operation has finished its run phase
        logic tout;
        int   ptr;
        int   ops;
        int   lat;
    } mdl_t;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic       mult_done;

    logic [3:0]  grant_w[2];
    logic [1:0]  idx_w[2];
    logic        clr_w[2];
    logic        en_w[2];
    logic [3:0]  ack_w[2];
    logic        err_w[2];
    logic        busy_w[2];
    logic [15:0] opc_w[2];
    logic [15:0] lat_w[2];

    mdl_t m[2];
    int   total;
    int   passed;

    mat_mult_sched #(.N_REQ(4), .TIMEOUT(8)) u_dut0 (
        .clk(clk), .reset(reset), .req(req), .grant(grant_w[0]), .grant_idx(idx_w[0]),
        .mult_clr(clr_w[0]), .enable_mult(en_w[0]), .mult_done(mult_done), .ack(ack_w[0]),
        .err(err_w[0]), .busy(busy_w[0]), .op_count(opc_w[0]), .last_latency(lat_w[0])
    );

    mat_mult_sched #(.N_REQ(4), .TIMEOUT(5)) u_dut1 (
        .clk(clk), .reset(reset), .req(req), .grant(grant_w[1]), .grant_idx(idx_w[1]),
        .mult_clr(clr_w[1]), .enable_mult(en_w[1]), .mult_done(mult_done), .ack(ack_w[1]),
        .err(err_w[1]), .busy(busy_w[1]), .op_count(opc_w[1]), .last_latency(lat_w[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int inst, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s dut%0d: got %0h, required %0h (t=%0t)", name, inst, act, exp,
                      $time);
    endtask

    // One operation-level step of the scheduler rules.
    function automatic mdl_t step(mdl_t s, logic rst_n, logic [3:0] r, logic d, int lim);
        mdl_t n;
        int   k;
        n = s;
        if (!rst_n) begin
            n.owner = -1; n.age = 0; n.run_len = 0; n.tout = 1'b0;
            n.ptr = 0; n.ops = 0; n.lat = 0;
            return n;
        end
        if (s.owner < 0) begin
            for (int i = 0; i < N; i++) begin
                k = (s.ptr + i) % N;
                if (n.owner < 0 && r[k]) begin
                    n.owner = k; n.ptr = (k + 1) % N;
                    n.age = 0; n.run_len = 0; n.tout = 1'b0;
                end
            end
        end else if (s.run_len != 0) begin
            n.owner = -1;
        end else begin
            if (s.age >= 1) begin
                if (d) begin
                    n.run_len = s.age; n.lat = s.age; n.ops = (s.ops + 1) % 65536;
                end else if (s.age == lim) begin
                    n.run_len = s.age; n.lat = lim; n.tout = 1'b1;
                    n.ops = (s.ops + 1) % 65536;
                end
            end
            n.age = s.age + 1;
        end
        return n;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) m[i] <= step(m[i], reset, req, mult_done, (i == 0) ? 8 : 5);
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            mdl_t       s;
            logic       own;
            logic       fin;
            logic [3:0] e_grant;
            s       = m[i];
            own     = (s.owner >= 0);
            fin     = own && (s.run_len != 0);
            e_grant = own ? (4'b0001 << s.owner) : 4'b0000;
            check("grant", i, 32'(grant_w[i]), 32'(e_grant));
            check("grant_idx", i, 32'(idx_w[i]), own ? 32'(s.owner) : 32'd0);
            check("mult_clr", i, 32'(clr_w[i]), 32'(own && s.age == 0));
            check("enable_mult", i, 32'(en_w[i]), 32'(own && s.age >= 1 && s.run_len == 0));
            check("ack", i, 32'(ack_w[i]), fin ? 32'(e_grant) : 32'd0);
            check("err", i, 32'(err_w[i]), 32'(fin && s.tout));
            check("busy", i, 32'(busy_w[i]), 32'(own));
            check("op_count", i, 32'(opc_w[i]), 32'(s.ops));
            check("last_latency", i, 32'(lat_w[i]), 32'(s.lat));
        end
    end

    // Stimulus helpers and per-test statistics (observed on instance 0 unless noted).
    logic [3:0] pend;
    logic [3:0] clr_grant;
    logic [3:0] last_ack;
    int done_at, run_seen;
    bit rr_mode, stale;
    int clr_cnt, en_cnt, ack_cnt, err_cnt, err1_cnt;
    int order_q[$];

    task automatic clear_stats();
        clr_cnt = 0; en_cnt = 0; ack_cnt = 0; err_cnt = 0; err1_cnt = 0;
        last_ack = 4'b0; clr_grant = 4'b0; order_q.delete();
    endtask

    task automatic tick();
        @(negedge clk);
        if (en_w[0]) begin run_seen++; en_cnt++; end
        else run_seen = 0;
        if (clr_w[0]) begin clr_cnt++; clr_grant = grant_w[0]; order_q.push_back(int'(idx_w[0])); end
        if (ack_w[0] != 4'b0) begin ack_cnt++; last_ack = ack_w[0]; if (err_w[0]) err_cnt++; end
        if (err_w[1]) err1_cnt++;
        mult_done = (done_at != 0 && en_w[0] && run_seen == done_at) || (stale && clr_w[0]);
        // Requesters drop on ack; in round-robin mode they reassert one cycle later.
        req  = (req | pend) & ~ack_w[0];
        pend = rr_mode ? ack_w[0] : 4'b0;
    endtask

    task automatic reset_dut(input int n);
        reset = 1'b0;
        repeat (n) tick();
        reset = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) m[i] = '{owner: -1, default: 0};
        total = 0; passed = 0;
        reset = 1'b0; req = 4'b0; pend = 4'b0; mult_done = 1'b0;
        done_at = 0; run_seen = 0; rr_mode = 1'b0; stale = 1'b0;
        clear_stats();

        // Single request, done on 3rd run cycle.
        reset_dut(2);
        check("reset_busy", 0, 32'(busy_w[0]), 32'd0);
        check("reset_grant", 0, 32'(grant_w[0]), 32'd0);
        clear_stats();
        done_at = 3; req = 4'b0001;
        repeat (10) tick();
        check("single_clr_grant", 0, 32'(clr_grant), 32'h1);
        check("single_clr_cycles", 0, 32'(clr_cnt), 32'd1);
        check("single_en_cycles", 0, 32'(en_cnt), 32'd3);
        check("single_ack_cycles", 0, 32'(ack_cnt), 32'd1);
        check("single_ack", 0, 32'(last_ack), 32'h1);
        check("single_err", 0, 32'(err_cnt), 32'd0);
        check("single_latency", 0, 32'(lat_w[0]), 32'd3);
        check("single_op_count", 0, 32'(opc_w[0]), 32'd1);

        // Round robin with all four requesters persistently asking.
        reset_dut(1);
        clear_stats();
        done_at = 2; rr_mode = 1'b1; req = 4'hF;
        for (int c = 0; c < 60 && order_q.size() < 5; c++) tick();
        rr_mode = 1'b0; req = 4'b0; pend = 4'b0;
        repeat (8) tick();
        check("rr_grants", 0, 32'(order_q.size()), 32'd5);
        if (order_q.size() >= 5) begin
            int exp_order[5];
            exp_order = '{0, 1, 2, 3, 0};
            for (int i = 0; i < 5; i++) check("rr_order", 0, 32'(order_q[i]), 32'(exp_order[i]));
        end

        // Watchdog: datapath never completes.
        reset_dut(1);
        clear_stats();
        done_at = 0; req = 4'b0100;
        repeat (16) tick();
        check("tmo_en_cycles", 0, 32'(en_cnt), 32'd8);
        check("tmo_ack", 0, 32'(last_ack), 32'h4);
        check("tmo_err_with_ack", 0, 32'(err_cnt), 32'd1);
        check("tmo_latency", 0, 32'(lat_w[0]), 32'd8);
        check("tmo_idle", 0, 32'(busy_w[0]), 32'd0);

        // Done coincides with the 5th run cycle: completion beats timeout on instance 1.
        reset_dut(1);
        clear_stats();
        done_at = 5; req = 4'b0001;
        repeat (12) tick();
        check("tie_err", 1, 32'(err1_cnt), 32'd0);
        check("tie_latency", 1, 32'(lat_w[1]), 32'd5);
        check("tie_latency", 0, 32'(lat_w[0]), 32'd5);

        // Stale done during the clear cycle must not end the operation.
        reset_dut(1);
        clear_stats();
        stale = 1'b1; done_at = 2; req = 4'b0010;
        repeat (10) tick();
        stale = 1'b0;
        check("stale_en_cycles", 0, 32'(en_cnt), 32'd2);
        check("stale_latency", 0, 32'(lat_w[0]), 32'd2);
        check("stale_ack", 0, 32'(last_ack), 32'h2);

        // Requester drops mid-run; ack is still pulsed.
        clear_stats();
        done_at = 4; req = 4'b1000;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (run_seen == 2) req = 4'b0;
        end
        check("drop_ack_cycles", 0, 32'(ack_cnt), 32'd1);
        check("drop_ack", 0, 32'(last_ack), 32'h8);
        check("drop_latency", 0, 32'(lat_w[0]), 32'd4);

        // Reset during run cycle 2.
        clear_stats();
        done_at = 0; req = 4'b0010;
        for (int c = 0; c < 10 && run_seen != 2; c++) tick();
        reset = 1'b0;
        tick();
        check("rst_grant", 0, 32'(grant_w[0]), 32'd0);
        check("rst_busy", 0, 32'(busy_w[0]), 32'd0);
        check("rst_enable", 0, 32'(en_w[0]), 32'd0);
        check("rst_op_count", 0, 32'(opc_w[0]), 32'd0);
        check("rst_latency", 0, 32'(lat_w[0]), 32'd0);
        reset = 1'b1;
        tick();
        tick();
        check("rst_regrant", 0, 32'(grant_w[0]), 32'h2);

        // Reset returns rr_ptr to 0: with 1010 pending, requester 1 must win.
        reset = 1'b0;
        tick();
        reset = 1'b1; req = 4'b1010;
        tick();
        check("rst_rr_ptr", 0, 32'(grant_w[0]), 32'h2);
        req = 4'b0; done_at = 1;
        repeat (10) tick();
        check("final_idle", 0, 32'(busy_w[0]), 32'd0);

        @(posedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
